fetch_unit_l1: RTL and testbench

- Instruction fetch front end: the initiator side of the instruction memory request/response interface.
- Generates sequential PCs and issues word reads carrying an opaque sequence tag.
- Tracks outstanding requests in an in-order PC FIFO and forwards returned instructions with their PCs to decode over val/rdy.
- A squash redirects the PC; responses to requests already in flight at the squash are drained and discarded.

---
 rtl/fetch_unit_l1.sv | 108 ++++++++++
 tb/tb_fetch_unit_l1.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_l1.sv
// Instruction fetch front end: issues sequential word reads, tracks them in an
// in-order PC FIFO and forwards returned instructions with their PCs to decode.
module fetch_unit_l1 #(
  parameter int unsigned p_opaq_bits     = 8,
  parameter logic [31:0] p_rst_addr      = 32'h00000200,
  parameter int unsigned p_max_in_flight = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [31:0]            mem_req_addr,
  output logic [p_opaq_bits-1:0] mem_req_opaque,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_opaq_bits-1:0] mem_resp_opaque,
  input  logic [31:0]            mem_resp_data,
  input  logic                   squash_val,
  input  logic [31:0]            squash_target,
  output logic                   d_val,
  input  logic                   d_rdy,
  output logic [31:0]            d_inst,
  output logic [31:0]            d_pc
);

  localparam int unsigned PW = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(p_max_in_flight);

  logic [31:0]            pc;
  logic [p_opaq_bits-1:0] tag;
  logic [PW-1:0]          head_ptr;
  logic [PW-1:0]          tail_ptr;
  logic [PW:0]            count;

  logic [31:0]            fifo_pc    [p_max_in_flight];
  logic [p_opaq_bits-1:0] fifo_tag   [p_max_in_flight];
  logic                   fifo_stale [p_max_in_flight];

  logic req_fire;
  logic resp_fire;
  logic not_empty;
  logic head_stale;

  assign not_empty  = (count != '0);
  assign head_stale = fifo_stale[head_ptr];

  assign mem_resp_rdy = not_empty & (head_stale | squash_val | d_rdy);
  assign resp_fire    = mem_resp_val & mem_resp_rdy;

  // A pop in the same cycle frees a slot, so a full FIFO may still accept a push.
  assign mem_req_val    = ~rst & ((count < FULL_CNT) | resp_fire);
  assign mem_req_addr   = pc;
  assign mem_req_opaque = tag;
  assign req_fire       = mem_req_val & mem_req_rdy;

  assign d_val  = ~rst & mem_resp_val & ~head_stale & ~squash_val;
  assign d_inst = mem_resp_data;
  assign d_pc   = fifo_pc[head_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= p_rst_addr;
      tag      <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < p_max_in_flight; i++) begin
        fifo_pc[i]    <= '0;
        fifo_tag[i]   <= '0;
        fifo_stale[i] <= 1'b0;
      end
    end else begin
      // Marking free slots stale too is harmless: a push rewrites the bit.
      if (squash_val) begin
        for (int unsigned i = 0; i < p_max_in_flight; i++) begin
          fifo_stale[i] <= 1'b1;
        end
      end
      if (req_fire) begin
        fifo_pc[tail_ptr]    <= pc;
        fifo_tag[tail_ptr]   <= tag;
        fifo_stale[tail_ptr] <= squash_val;
        tail_ptr             <= tail_ptr + 1'b1;
        tag                  <= tag + 1'b1;
      end
      if (squash_val) begin
        pc <= squash_target;
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (resp_fire) begin
        head_ptr <= head_ptr + 1'b1;
      end
      case ({req_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  resp_when_empty: assert property (@(posedge clk) disable iff (rst)
    mem_resp_val |-> not_empty);

  resp_tag_match: assert property (@(posedge clk) disable iff (rst)
    (mem_resp_val && not_empty) |-> (mem_resp_opaque == fifo_tag[head_ptr]));

endmodule

// File: tb/tb_fetch_unit_l1.sv
// Directed bench for fetch_unit_l1 with an in-order 1-cycle memory responder;
// 2-bit tags so the sequence tag wraps during normal traffic.
module tb_fetch_unit_l1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_val;
  logic        mem_req_rdy = 1'b0;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_opaque;
  logic        mem_resp_val = 1'b0;
  logic        mem_resp_rdy;
  logic [1:0]  mem_resp_opaque = '0;
  logic [31:0] mem_resp_data = '0;
  logic        squash_val = 1'b0;
  logic [31:0] squash_target = '0;
  logic        d_val;
  logic        d_rdy = 1'b1;
  logic [31:0] d_inst;
  logic [31:0] d_pc;

  fetch_unit_l1 #(
    .p_opaq_bits    (2),
    .p_rst_addr     (32'h00000200),
    .p_max_in_flight(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_val    (mem_req_val),
    .mem_req_rdy    (mem_req_rdy),
    .mem_req_addr   (mem_req_addr),
    .mem_req_opaque (mem_req_opaque),
    .mem_resp_val   (mem_resp_val),
    .mem_resp_rdy   (mem_resp_rdy),
    .mem_resp_opaque(mem_resp_opaque),
    .mem_resp_data  (mem_resp_data),
    .squash_val     (squash_val),
    .squash_target  (squash_target),
    .d_val          (d_val),
    .d_rdy          (d_rdy),
    .d_inst         (d_inst),
    .d_pc           (d_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  tag;
    logic [31:0] rdy;
  } pend_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  pend_t       pend[$];
  ent_t        req_log[$];
  ent_t        d_log[$];
  logic        resp_en = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_mem();
    if (resp_en && pend.size() != 0 && pend[0].rdy <= cyc) begin
      mem_resp_val    = 1'b1;
      mem_resp_opaque = pend[0].tag;
      mem_resp_data   = mem_word(pend[0].addr);
    end else begin
      mem_resp_val    = 1'b0;
      mem_resp_opaque = '0;
      mem_resp_data   = '0;
    end
  endtask

  task automatic tick();
    logic        rf, pf, df;
    logic [31:0] ra, dp, di;
    logic [1:0]  rt;
    drive_mem();
    @(negedge clk);
    rf = mem_req_val & mem_req_rdy;
    pf = mem_resp_val & mem_resp_rdy;
    df = d_val & d_rdy;
    ra = mem_req_addr;
    rt = mem_req_opaque;
    dp = d_pc;
    di = d_inst;
    @(posedge clk);
    #1;
    cyc++;
    if (pf) void'(pend.pop_front());
    if (rf) begin
      pend.push_back('{addr: ra, tag: rt, rdy: cyc});
      req_log.push_back('{a: ra, b: {30'd0, rt}});
    end
    if (df) d_log.push_back('{a: dp, b: di});
    drive_mem();
    #1;
  endtask

  task automatic drain(input string name);
    mem_req_rdy = 1'b0;
    for (int k = 0; k < 20 && pend.size() != 0; k++) tick();
    check(name, pend.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend.delete();
    req_log.delete();
    d_log.delete();
    resp_en = 1'b0;
    mem_req_rdy = 1'b0;
    squash_val = 1'b0;
    d_rdy = 1'b1;
    drive_mem();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check("rst_req_val", mem_req_val, 0);
    check("rst_d_val", d_val, 0);
    check("rst_resp_rdy", mem_resp_rdy, 0);
    do_reset();
    check("post_rst_req_val", mem_req_val, 1);
    check("post_rst_addr", mem_req_addr, 32'h200);
    check("post_rst_tag", mem_req_opaque, 0);

    // Boot: steady flow
    mem_req_rdy = 1'b1; resp_en = 1'b1; d_rdy = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    drain("boot_drain");
    check("boot_nreq", req_log.size(), 4);
    check("boot_nd", d_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("boot_req_addr", req_log[i].a, 32'h200 + 32'(4*i));
      check("boot_req_tag", req_log[i].b, 32'(i));
      check("boot_d_pc", d_log[i].a, 32'h200 + 32'(4*i));
      check("boot_d_inst", d_log[i].b, mem_word(32'h200 + 32'(4*i)));
    end

    // Memory stall fills the FIFO, then issue resumes on the pop cycle
    do_reset();
    mem_req_rdy = 1'b1; resp_en = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("stall_nreq", req_log.size(), 4);
    check("stall_last_addr", req_log[3].a, 32'h20C);
    check("stall_req_val", mem_req_val, 0);
    resp_en = 1'b1;
    drive_mem();
    #1;
    check("stall_pop_req_val", mem_req_val, 1);
    check("stall_pop_addr", mem_req_addr, 32'h210);
    tick();
    check("stall_pop_nreq", req_log.size(), 5);
    check("stall_pop_tag", req_log[4].b, 0);
    check("stall_pop_nd", d_log.size(), 1);
    drain("stall_drain");
    check("stall_nd", d_log.size(), 5);
    check("stall_d0_pc", d_log[0].a, 32'h200);
    check("stall_d4_pc", d_log[4].a, 32'h210);

    // Decode backpressure
    do_reset();
    d_rdy = 1'b0; resp_en = 1'b1; mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_rdy", mem_resp_rdy, 0);
      check("bp_d_val", d_val, 1);
      check("bp_d_pc", d_pc, 32'h200);
      check("bp_d_inst", d_inst, mem_word(32'h200));
      tick();
    end
    check("bp_held_nd", d_log.size(), 0);
    d_rdy = 1'b1;
    #1;
    check("bp_release_rdy", mem_resp_rdy, 1);
    tick();
    tick();
    tick();
    check("bp_nd", d_log.size(), 1);
    check("bp_d_pc_out", d_log[0].a, 32'h200);

    // Squash with three requests in flight
    do_reset();
    resp_en = 1'b0; mem_req_rdy = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    mem_req_rdy = 1'b0; resp_en = 1'b1;
    tick();
    check("sq_first_nd", d_log.size(), 1);
    resp_en = 1'b0; squash_val = 1'b1; squash_target = 32'h400;
    tick();
    squash_val = 1'b0; resp_en = 1'b1; mem_req_rdy = 1'b1;
    for (int k = 0; k < 30 && d_log.size() < 3; k++) tick();
    drain("sq_drain");
    check("sq_nd", d_log.size(), 6);
    check("sq_d0_pc", d_log[0].a, 32'h200);
    check("sq_d1_pc", d_log[1].a, 32'h400);
    check("sq_d1_inst", d_log[1].b, mem_word(32'h400));
    check("sq_d2_pc", d_log[2].a, 32'h404);
    check("sq_req4_addr", req_log[4].a, 32'h400);
    check("sq_req4_tag", req_log[4].b, 0);

    // Squash coinciding with a response and a request handshake
    do_reset();
    mem_req_rdy = 1'b1; resp_en = 1'b1; d_rdy = 1'b1;
    tick();
    squash_val = 1'b1; squash_target = 32'h400;
    #1;
    check("sqr_d_val", d_val, 0);
    check("sqr_resp_rdy", mem_resp_rdy, 1);
    check("sqr_req_addr", mem_req_addr, 32'h204);
    tick();
    squash_val = 1'b0;
    #1;
    check("sqr_next_addr", mem_req_addr, 32'h400);
    check("sqr_next_val", mem_req_val, 1);
    for (int k = 0; k < 20 && d_log.size() < 1; k++) tick();
    drain("sqr_drain");
    check("sqr_nd", d_log.size(), 2);
    check("sqr_d0_pc", d_log[0].a, 32'h400);
    check("sqr_d1_pc", d_log[1].a, 32'h404);
    check("sqr_req2_tag", req_log[2].b, 2);

    // Reset with two requests outstanding
    do_reset();
    resp_en = 1'b0; mem_req_rdy = 1'b1;
    tick();
    tick();
    mem_req_rdy = 1'b0; resp_en = 1'b1;
    drive_mem();
    #1;
    check("mrst_pre_d_val", d_val, 1);
    rst = 1'b1;
    pend.delete();
    req_log.delete();
    d_log.delete();
    drive_mem();
    #1;
    check("mrst_req_val", mem_req_val, 0);
    check("mrst_d_val", d_val, 0);
    check("mrst_resp_rdy", mem_resp_rdy, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mrst_addr", mem_req_addr, 32'h200);
    check("mrst_tag", mem_req_opaque, 0);
    mem_req_rdy = 1'b1;
    tick();
    drain("mrst_drain");
    check("mrst_nd", d_log.size(), 1);
    check("mrst_d_pc", d_log[0].a, 32'h200);

    // Tag wrap over ten fetches
    do_reset();
    mem_req_rdy = 1'b1; resp_en = 1'b1; d_rdy = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    drain("wrap_drain");
    check("wrap_nreq", req_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check("wrap_tag", req_log[i].b, 32'(i % 4));
    end
    check("wrap_nd", d_log.size(), 10);
    check("wrap_last_pc", d_log[9].a, 32'h224);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
